// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared types and constants for the pipeline MEM stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int WORD_W      = 32;
  localparam int REG_IDX_W   = 5;
  localparam int DEF_TIMEOUT = 16;

  // MEM-stage access sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_ctr
// Description : Bus-wait counter. load clears it, en advances it, tc_o flags
//               that the last permitted wait cycle has been reached.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_ctr #(
  parameter int TERM  = 16,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority so a fresh access always starts at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == CNT_W'(TERM - 1));

endmodule : mem_timeout_ctr
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline MEM stage. Issues word loads/stores on a req/ack
//               bus, stalls upstream while an access is outstanding and
//               hands a bubble or the completed result to MEM/WB. Flags
//               misaligned accesses and bus timeouts.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import pipe_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 MemRead,
  input  logic                 MemWrite,
  input  logic                 RegWrite,
  input  logic                 MemToReg,
  input  logic [WORD_W-1:0]    ALUresult,
  input  logic [WORD_W-1:0]    WriteData,
  input  logic [REG_IDX_W-1:0] intr2011,
  output logic                 RegWriteOut,
  output logic                 MemToRegOut,
  output logic [WORD_W-1:0]    ReadData,
  output logic [WORD_W-1:0]    ALUresultOut,
  output logic [REG_IDX_W-1:0] intr2011Out,
  output logic                 stall,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_W-1:0]    mem_addr,
  output logic [WORD_W-1:0]    mem_wdata,
  input  logic [WORD_W-1:0]    mem_rdata,
  input  logic                 mem_ack,
  output logic                 align_err,
  output logic                 bus_err
);

  mem_state_e         state_q;
  mem_state_e         state_d;

  logic               req_q;
  logic               we_q;
  logic [WORD_W-1:0]  addr_q;
  logic [WORD_W-1:0]  wdata_q;
  logic [WORD_W-1:0]  rdata_q;
  logic               align_err_q;
  logic               bus_err_q;

  logic               w_access;
  logic               w_mis;
  logic               w_ctr_load;
  logic               w_ctr_en;
  logic               w_ctr_tc;
  logic               w_start;
  logic               w_timeout;

  assign w_access  = MemRead | MemWrite;
  assign w_mis     = w_access & (ALUresult[1:0] != 2'b00);
  assign w_start   = (state_q == IDLE) & w_access & ~w_mis;
  assign w_timeout = (state_q == WAIT) & ~mem_ack & w_ctr_tc;

  mem_timeout_ctr #(
    .TERM  (TIMEOUT),
    .CNT_W (CNT_W)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (w_ctr_load),
    .en_i   (w_ctr_en),
    .tc_o   (w_ctr_tc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, stall and MEM/WB control; a bubble is RegWriteOut = 0
  always_comb begin
    state_d     = state_q;
    stall       = 1'b0;
    RegWriteOut = RegWrite;
    ReadData    = '0;
    w_ctr_load  = 1'b0;
    w_ctr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (w_access) begin
          RegWriteOut = 1'b0;
          if (!w_mis) begin
            stall      = 1'b1;
            w_ctr_load = 1'b1;
            state_d    = WAIT;
          end
        end
      end
      WAIT: begin
        stall       = 1'b1;
        RegWriteOut = 1'b0;
        if (mem_ack || w_ctr_tc) begin
          state_d = DONE;
        end else begin
          w_ctr_en = 1'b1;
        end
      end
      DONE: begin
        // bus_err_q is high exactly in the DONE cycle that follows a timeout
        RegWriteOut = RegWrite & ~bus_err_q;
        ReadData    = rdata_q;
        state_d     = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus request, captured read data and one-cycle error pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      align_err_q <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      align_err_q <= (state_q == IDLE) & w_mis;
      bus_err_q   <= w_timeout;
      if (w_start) begin
        // MemRead & MemWrite together behave as a store
        req_q   <= 1'b1;
        we_q    <= MemWrite;
        addr_q  <= {ALUresult[WORD_W-1:2], 2'b00};
        wdata_q <= WriteData;
        rdata_q <= '0;
      end else if (state_q == WAIT) begin
        if (mem_ack) begin
          req_q <= 1'b0;
          if (!we_q) begin
            rdata_q <= mem_rdata;
          end
        end else if (w_ctr_tc) begin
          req_q   <= 1'b0;
          rdata_q <= '0;
        end
      end
    end
  end

  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign align_err    = align_err_q;
  assign bus_err      = bus_err_q;
  assign MemToRegOut  = MemToReg;
  assign ALUresultOut = ALUresult;
  assign intr2011Out  = intr2011;

endmodule : mem_access_stage
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage. Each instruction is
//               expanded by a transaction-level model into its expected
//               cycle timeline (bubble/stall cycles, bus cycles, result).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        MemRead = 1'b0, MemWrite = 1'b0, RegWrite = 1'b0, MemToReg = 1'b0;
  logic [31:0] ALUresult = '0, WriteData = '0;
  logic [4:0]  intr2011 = '0;
  logic        RegWriteOut, MemToRegOut;
  logic [31:0] ReadData, ALUresultOut;
  logic [4:0]  intr2011Out;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        align_err, bus_err;

  int n_cmp = 0;
  int n_err = 0;
  bit pend_align = 1'b0;

  mem_access_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .MemToReg(MemToReg),
    .ALUresult(ALUresult), .WriteData(WriteData), .intr2011(intr2011),
    .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut), .ReadData(ReadData),
    .ALUresultOut(ALUresultOut), .intr2011Out(intr2011Out), .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .align_err(align_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit rd, input bit wr, input bit rw, input bit m2r,
                        input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] idx);
    MemRead = rd; MemWrite = wr; RegWrite = rw; MemToReg = m2r;
    ALUresult = alu; WriteData = wd; intr2011 = idx;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Non-memory instruction: one zero-latency pass-through cycle; a stray ack is ignored
  task automatic do_nonmem(input bit rw, input bit m2r, input logic [31:0] alu, input logic [4:0] idx);
    set_in(1'b0, 1'b0, rw, m2r, alu, $urandom, idx);
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    @(negedge clk);
    chk("np_regwrite", RegWriteOut, rw);
    chk("np_memtoreg", MemToRegOut, m2r);
    chk("np_alu", ALUresultOut, alu);
    chk("np_rd", intr2011Out, idx);
    chk("np_stall", stall, 0);
    chk("np_req", mem_req, 0);
    chk("np_readdata", ReadData, 0);
    chk("np_align", align_err, pend_align);
    chk("np_bus", bus_err, 0);
    pend_align = 1'b0;
    next_cycle();
    mem_ack = 1'b0;
  endtask

  // Misaligned access: suppressed, no stall, align_err one cycle later
  task automatic do_mis(input bit rd, input bit wr, input bit rw, input logic [31:0] alu);
    set_in(rd, wr, rw, 1'b1, alu, $urandom, 5'($urandom));
    @(negedge clk);
    chk("mis_stall", stall, 0);
    chk("mis_regwrite", RegWriteOut, 0);
    chk("mis_req", mem_req, 0);
    chk("mis_align", align_err, pend_align);
    pend_align = 1'b1;
    next_cycle();
  endtask

  // Aligned access; ack_k = WAIT cycle carrying the ack (outside 1..TO means no ack)
  task automatic do_access(input bit rd, input bit wr, input bit rw, input bit m2r,
                           input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] idx,
                           input int ack_k, input logic [31:0] rdata);
    bit acked = 1'b0;
    bit is_load;
    is_load = rd & ~wr;
    set_in(rd, wr, rw, m2r, alu, wd, idx);
    @(negedge clk);
    chk("acc0_stall", stall, 1);
    chk("acc0_regwrite", RegWriteOut, 0);
    chk("acc0_req", mem_req, 0);
    chk("acc0_align", align_err, pend_align);
    pend_align = 1'b0;
    next_cycle();
    for (int i = 1; i <= TO; i++) begin
      mem_ack   = (i == ack_k);
      mem_rdata = (i == ack_k) ? rdata : $urandom;
      @(negedge clk);
      chk("wait_stall", stall, 1);
      chk("wait_regwrite", RegWriteOut, 0);
      chk("wait_req", mem_req, 1);
      chk("wait_we", mem_we, wr);
      chk("wait_addr", mem_addr, alu);
      chk("wait_wdata", mem_wdata, wd);
      chk("wait_align", align_err, 0);
      chk("wait_bus", bus_err, 0);
      next_cycle();
      if (i == ack_k) begin
        acked = 1'b1;
        break;
      end
    end
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    @(negedge clk);
    chk("done_stall", stall, 0);
    chk("done_req", mem_req, 0);
    chk("done_bus", bus_err, !acked);
    chk("done_align", align_err, 0);
    chk("done_regwrite", RegWriteOut, rw & acked);
    chk("done_memtoreg", MemToRegOut, m2r);
    chk("done_readdata", ReadData, (is_load && acked) ? rdata : 32'h0);
    chk("done_rd", intr2011Out, idx);
    next_cycle();
  endtask

  initial begin
    bit rd, wr;
    int kind;
    logic [31:0] a;

    // Reset state
    #2;
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_align", align_err, 0);
    chk("rst_bus", bus_err, 0);
    chk("rst_stall", stall, 0);
    chk("rst_readdata", ReadData, 0);
    next_cycle();
    next_cycle();
    rst_n = 1'b1;

    // Directed scenarios
    do_nonmem(1'b1, 1'b0, 32'h1234, 5'd7);
    do_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd3, 3, 32'hDEADBEEF);
    do_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h204, 32'hA5A5A5A5, 5'd0, 1, 32'h11111111);
    do_mis(1'b1, 1'b0, 1'b1, 32'h103);
    do_nonmem(1'b0, 1'b0, 32'h55, 5'd1);
    do_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd9, 0, 32'hCAFEF00D);
    do_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 5'd4, 1, 32'h01234567);
    do_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h404, 32'h0, 5'd5, 2, 32'h89ABCDEF);
    do_access(1'b1, 1'b1, 1'b1, 1'b0, 32'h408, 32'h77, 5'd6, 1, 32'hFFFF0000);
    do_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h40C, 32'h0, 5'd8, TO, 32'h0BADF00D);

    // Reset in the middle of a WAIT
    set_in(1'b1, 1'b0, 1'b1, 1'b1, 32'h500, 32'h0, 5'd2);
    next_cycle();
    @(negedge clk);
    chk("rstw_req_before", mem_req, 1);
    rst_n = 1'b0;
    #1;
    chk("rstw_req_drop", mem_req, 0);
    chk("rstw_bus", bus_err, 0);
    chk("rstw_align", align_err, 0);
    next_cycle();
    set_in(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 5'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) do_nonmem(1'b1, 1'b0, $urandom, 5'($urandom));

    // Randomized instruction stream
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 3);
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      case (kind)
        0: do_nonmem(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, 5'($urandom));
        1: begin
          a = ($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
          do_mis(rd, wr, 1'($urandom_range(0, 1)), a);
        end
        default: begin
          a = $urandom & 32'hFFFF_FFFC;
          do_access(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
                    $urandom, 5'($urandom), $urandom_range(0, TO + 1), $urandom);
        end
      endcase
    end
    do_nonmem(1'b0, 1'b0, 32'h0, 5'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_access_stage
`default_nettype wire
